// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin UART TX scheduler with baud clock enable; optional inter-frame gap via UART_TX_SCHED_GAP_EN
module uart_tx_sched #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             req0_valid_i,
  input  logic [8:0]       req0_data_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [8:0]       req1_data_i,
  output logic             req1_ready_o,
  input  logic             tx_rdy_i,
  output logic             tx_start_o,
  output logic [8:0]       tx_data_o,
  output logic             clk_en_o,
  output logic             grant_o,
  output logic             busy_o
`ifdef UART_TX_SCHED_GAP_EN
  ,
  input  logic [7:0]       gap_i
`endif
);

`ifdef UART_TX_SCHED_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;
`endif

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [8:0]       data_q, data_d;
  logic             grant_q, grant_d;
  logic             baud_zero;
  logic             any_valid;
  logic             win;
`ifdef UART_TX_SCHED_GAP_EN
  logic [7:0]       gap_q, gap_d;
`endif

  // Baud divider: a zero count is the enable cycle and the only point where a new divisor is taken.
  always_comb begin
    baud_zero = (cnt_q == '0);
    cnt_d     = baud_zero ? baud_div_i : cnt_q - DIV_W'(1);
  end

  // Enable is masked by reset so the zeroed counter cannot leak a pulse while held in reset.
  assign clk_en_o = baud_zero & rst_ni;

  // Scheduler: round-robin pick in IDLE, then follow the transmitter's idle flag through the frame.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    grant_d      = grant_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
`ifdef UART_TX_SCHED_GAP_EN
    gap_d        = gap_q;
`endif
    any_valid    = req0_valid_i | req1_valid_i;
    // On a tie the requester that did not own the last frame wins.
    win          = (req0_valid_i & req1_valid_i) ? ~grant_q : req1_valid_i;
    case (state_q)
      S_IDLE: begin
        if (en_i && tx_rdy_i && any_valid) begin
          data_d       = win ? req1_data_i : req0_data_i;
          grant_d      = win;
          req0_ready_o = ~win;
          req1_ready_o = win;
          state_d      = S_START;
        end
      end
      S_START: begin
        if (!tx_rdy_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_rdy_i) begin
`ifdef UART_TX_SCHED_GAP_EN
          state_d = S_GAP;
          gap_d   = gap_i;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef UART_TX_SCHED_GAP_EN
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else if (baud_zero) gap_d = gap_q - 8'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; grant resets to 1 so req0 takes the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= 9'd0;
      grant_q <= 1'b1;
`ifdef UART_TX_SCHED_GAP_EN
      gap_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      grant_q <= grant_d;
`ifdef UART_TX_SCHED_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign tx_start_o = (state_q == S_START);
  assign tx_data_o  = data_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched with a simple transmitter model
module tb_uart_tx_sched;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [15:0] baud_div_i;
  logic        req0_valid_i, req1_valid_i;
  logic [8:0]  req0_data_i, req1_data_i;
  logic        req0_ready_o, req1_ready_o;
  logic        tx_rdy_i;
  logic        tx_start_o;
  logic [8:0]  tx_data_o;
  logic        clk_en_o;
  logic        grant_o;
  logic        busy_o;
`ifdef UART_TX_SCHED_GAP_EN
  logic [7:0]  gap_i;
`endif

  always #5 clk_i = ~clk_i;

  uart_tx_sched #(.DIV_W(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .baud_div_i   (baud_div_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .tx_rdy_i     (tx_rdy_i),
    .tx_start_o   (tx_start_o),
    .tx_data_o    (tx_data_o),
    .clk_en_o     (clk_en_o),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
`ifdef UART_TX_SCHED_GAP_EN
    ,
    .gap_i        (gap_i)
`endif
  );

  int         n_tests = 0;
  int         n_fail = 0;
  logic [9:0] sb[$];
  logic       m_last;
  logic       pend_chk;
  logic [9:0] pend;
  logic [7:0] gnt_hist;
  int         ready_cnt, en_cnt, st_run, st_seen, hold;
  int         en_since, cyc_since, lat_en, lat_cyc;
  logic       tx_auto, tx_man, rose, rose_d;
  logic       s_start, s_busy;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic rdy_any;
    rdy_any = req0_ready_o | req1_ready_o;
    s_start = tx_start_o;
    s_busy  = busy_o;
    if (clk_en_o) en_cnt++;
    if (pend_chk) begin
      check_eq("tx_data", 32'(tx_data_o), 32'(pend[8:0]));
      check_eq("grant", 32'(grant_o), 32'(pend[9]));
      check_eq("tx_start_after_grant", 32'(tx_start_o), 32'd1);
      check_eq("busy_in_frame", 32'(busy_o), 32'd1);
      pend_chk = 1'b0;
    end
    if (rdy_any) begin
      check_eq("ready_onehot", 32'(req0_ready_o & req1_ready_o), 32'd0);
      if (req0_ready_o) check_eq("ready0_valid", 32'(req0_valid_i), 32'd1);
      if (req1_ready_o) check_eq("ready1_valid", 32'(req1_valid_i), 32'd1);
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        pend = sb.pop_front();
        check_eq("grant_id", 32'(req1_ready_o), 32'(pend[9]));
        pend_chk = 1'b1;
      end
      gnt_hist = {gnt_hist[6:0], req1_ready_o};
      ready_cnt++;
    end
    if (rose_d) begin
`ifndef UART_TX_SCHED_GAP_EN
      check_eq("busy_after_rise", 32'(busy_o), 32'd0);
`endif
      rose_d = 1'b0;
    end
    if (rose) begin
      rose = 1'b0;
      if (busy_o) begin
        check_eq("no_grant_on_rise", 32'(rdy_any), 32'd0);
        rose_d = 1'b1;
      end
      en_since  = 0;
      cyc_since = 0;
    end else begin
      if (clk_en_o) en_since++;
      cyc_since++;
    end
    if (tx_start_o) begin
      if (st_run == 0) begin
        lat_en  = en_since;
        lat_cyc = cyc_since;
      end
      st_run++;
    end else if (st_run != 0) begin
      if (tx_auto) check_eq("start_len", 32'(st_run), 32'd3);
      st_run = 0;
    end
  endtask

  task automatic tx_model();
    if (!tx_auto) begin
      tx_rdy_i = tx_man;
      st_seen  = 0;
    end else if (tx_rdy_i && s_start) begin
      st_seen++;
      if (st_seen == 2) begin
        tx_rdy_i = 1'b0;
        st_seen  = 0;
        hold     = 6;
      end
    end else if (!tx_rdy_i) begin
      if (hold == 0) begin
        tx_rdy_i = 1'b1;
        rose     = 1'b1;
      end else begin
        hold--;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
    tx_model();
  endtask

  task automatic expect_grant();
    logic w;
    w = (req0_valid_i && req1_valid_i) ? ~m_last : req1_valid_i;
    m_last = w;
    sb.push_back({w, w ? req1_data_i : req0_data_i});
  endtask

  task automatic wait_ready();
    int c;
    c = ready_cnt;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ready_cnt != c) break;
    end
    check_eq("ready_seen", 32'(ready_cnt != c), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!s_busy) break;
    end
    check_eq("idle_reached", 32'(s_busy), 32'd0);
  endtask

  initial begin
    int c;
    rst_ni = 1'b0; en_i = 1'b1; baud_div_i = 16'd3;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; req0_data_i = 9'd0; req1_data_i = 9'd0;
    tx_rdy_i = 1'b1; tx_auto = 1'b1; tx_man = 1'b1;
`ifdef UART_TX_SCHED_GAP_EN
    gap_i = 8'd0;
`endif
    m_last = 1'b1; pend_chk = 1'b0; pend = '0; gnt_hist = '0;
    ready_cnt = 0; en_cnt = 0; st_run = 0; st_seen = 0; hold = 0;
    en_since = 0; cyc_since = 0; lat_en = 0; lat_cyc = 0;
    rose = 1'b0; rose_d = 1'b0; s_start = 1'b0; s_busy = 1'b0;

    repeat (2) tick();
    check_eq("rst_tx_start", 32'(tx_start_o), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data_o), 32'd0);
    check_eq("rst_clk_en", 32'(clk_en_o), 32'd0);
    check_eq("rst_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
    check_eq("rst_grant", 32'(grant_o), 32'd1);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    #1;
    check_eq("clk_en_first", 32'(clk_en_o), 32'd1);
    tick();
    check_eq("clk_en_after_load", 32'(clk_en_o), 32'd0);

    en_cnt = 0;
    repeat (40) tick();
    check_eq("baud3_pulses", 32'(en_cnt), 32'd10);
    baud_div_i = 16'd0;
    repeat (4) tick();
    en_cnt = 0;
    repeat (20) tick();
    check_eq("baud0_pulses", 32'(en_cnt), 32'd20);
    baud_div_i = 16'd1;
    repeat (2) tick();

    gnt_hist = '0;
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    for (int f = 0; f < 4; f++) begin
      req0_data_i = 9'(9'h100 + f);
      req1_data_i = 9'(9'h0A0 + f);
      expect_grant();
      wait_ready();
    end
    tick();
    check_eq("rr_order", 32'(gnt_hist[3:0]), 32'h5);
`ifdef UART_TX_SCHED_GAP_EN
    check_eq("b2b_latency", 32'(lat_cyc), 32'd3);
`else
    check_eq("b2b_latency", 32'(lat_cyc), 32'd2);
`endif
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    wait_idle();

    req0_valid_i = 1'b1;
    req0_data_i  = 9'h155;
    expect_grant();
    wait_ready();
    req0_valid_i = 1'b0;
    wait_idle();

    req0_valid_i = 1'b1;
    req0_data_i  = 9'h0F0;
    expect_grant();
    wait_ready();
    req0_valid_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (s_busy && !s_start) break;
    end
    check_eq("in_wait", 32'(s_busy & ~s_start), 32'd1);
    en_i = 1'b0;
    req0_valid_i = 1'b1; req0_data_i = 9'h011;
    req1_valid_i = 1'b1; req1_data_i = 9'h122;
    expect_grant();
    c = ready_cnt;
    wait_idle();
    repeat (20) tick();
    check_eq("en0_no_grant", 32'(ready_cnt - c), 32'd0);
    check_eq("en0_idle", 32'(s_busy), 32'd0);
    en_i = 1'b1;
    wait_ready();
    if (m_last) req1_valid_i = 1'b0;
    else        req0_valid_i = 1'b0;
    expect_grant();
    wait_ready();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    wait_idle();

    tx_auto = 1'b0;
    tx_man  = 1'b0;
    tick();
    req0_valid_i = 1'b1;
    req0_data_i  = 9'h033;
    expect_grant();
    c = ready_cnt;
    repeat (10) tick();
    check_eq("txrdy_low_no_grant", 32'(ready_cnt - c), 32'd0);
    check_eq("txrdy_low_idle", 32'(s_busy), 32'd0);
    tx_auto = 1'b1;
    wait_ready();
    req0_valid_i = 1'b0;
    wait_idle();

`ifdef UART_TX_SCHED_GAP_EN
    gap_i = 8'd2;
    baud_div_i = 16'd1;
    req0_valid_i = 1'b1;
    req0_data_i  = 9'h0C3;
    expect_grant();
    wait_ready();
    req0_data_i  = 9'h03C;
    expect_grant();
    wait_ready();
    req0_valid_i = 1'b0;
    tick();
    check_eq("gap_pulses_ge2", 32'(lat_en >= 2), 32'd1);
    gap_i = 8'd0;
    wait_idle();
`endif

    tx_auto = 1'b0;
    tx_man  = 1'b1;
    tick();
    req1_valid_i = 1'b1;
    req1_data_i  = 9'h1A5;
    expect_grant();
    wait_ready();
    req1_valid_i = 1'b0;
    check_eq("start_pre_rst", 32'(tx_start_o), 32'd1);
    check_eq("data_pre_rst", 32'(tx_data_o), 32'h1A5);
    rst_ni = 1'b0;
    #1;
    check_eq("midrst_tx_start", 32'(tx_start_o), 32'd0);
    check_eq("midrst_busy", 32'(busy_o), 32'd0);
    check_eq("midrst_tx_data", 32'(tx_data_o), 32'd0);
    check_eq("midrst_grant", 32'(grant_o), 32'd1);
    check_eq("midrst_clk_en", 32'(clk_en_o), 32'd0);
    pend_chk = 1'b0;
    sb.delete();
    m_last = 1'b1;
    st_run = 0;
    repeat (3) tick();
    rst_ni  = 1'b1;
    tx_auto = 1'b1;
    req0_valid_i = 1'b1; req0_data_i = 9'h0AA;
    req1_valid_i = 1'b1; req1_data_i = 9'h155;
    expect_grant();
    wait_ready();
    check_eq("tie_after_rst", 32'(grant_o), 32'd0);
    req0_valid_i = 1'b0;
    expect_grant();
    wait_ready();
    req1_valid_i = 1'b0;
    wait_idle();

    repeat (3) tick();
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
- REQ-001 SHALL have parameter DIV_W, default 16, width of the baud divisor.
- REQ-002 SHALL have port clk_i  input  1  system clock; all logic on its rising edge.
- REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
- REQ-004 SHALL have port en_i  input  1  scheduler enable; gates new grants only.
- REQ-005 SHALL have port baud_div_i  input  DIV_W  baud divisor; the clock-enable period is baud_div_i+1 cycles.
- REQ-006 SHALL have ports req0_valid_i / req1_valid_i  input  1  requester has a 9-bit word to send.
- REQ-007 SHALL have ports req0_data_i / req1_data_i  input  9  requester word.
- REQ-008 SHALL have ports req0_ready_o / req1_ready_o  output  1  one-cycle accept pulse to the requester.
- REQ-009 SHALL have port tx_rdy_i  input  1  transmitter idle flag (high = IDLE).
- REQ-010 SHALL have port tx_start_o  output  1  frame start request to the transmitter.
- REQ-011 SHALL have port tx_data_o  output  9  registered word to the transmitter.
- REQ-012 SHALL have port clk_en_o  output  1  bit-rate clock enable to the transmitter.
- REQ-013 SHALL have port grant_o  output  1  requester owning the current or last frame.
- REQ-014 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
- REQ-015 SHALL keep a DIV_W-bit down-counter: at zero, pulse clk_en_o high for 1 cycle and reload baud_div_i; otherwise decrement.
- REQ-016 SHALL hold clk_en_o high every cycle when baud_div_i=0.
- REQ-017 SHALL sample a baud_div_i change only at reload.
- REQ-018 SHALL implement states IDLE, START, WAIT, GAP.
- REQ-019 SHALL, in IDLE with en_i=1, tx_rdy_i=1 and at least one valid: pick the winner, latch its data into tx_data_o, pulse its ready_o for 1 cycle, set grant_o, and go to START.
- REQ-020 SHALL arbitrate round-robin: when both are valid, grant the requester other than grant_o; after reset, req0 wins the first tie.
- REQ-021 SHALL assert ready_o only in the cycle it latches data; a requester whose valid is low SHALL never see ready_o.
- REQ-022 SHALL assert tx_start_o during START and hold it until tx_rdy_i is sampled low, then deassert it and go to WAIT.
- REQ-023 SHALL leave WAIT when tx_rdy_i is sampled high, going to GAP (REQ-032) or to IDLE (REQ-033).
- REQ-024 SHALL hold tx_data_o stable from latch until the next grant.
- REQ-025 SHALL never issue a grant in the same cycle tx_rdy_i rises; the earliest next grant is the following cycle in IDLE.
- REQ-026 SHALL, with en_i=0, make no new grants; a frame already in START, WAIT or GAP SHALL complete normally.
- REQ-027 SHALL wait in IDLE with no ready pulse if tx_rdy_i=0 while in IDLE.
- REQ-028 SHALL drive busy_o = (state != IDLE).

Reset
- REQ-029 SHALL, on rst_ni low at any time including mid-frame, immediately force: state IDLE, tx_start_o 0, tx_data_o 0, clk_en_o 0, req ready_o 0, grant_o 1 (so req0 wins the first tie), busy_o 0, baud counter 0, gap counter 0.
- REQ-030 SHALL, after rst_ni rises, load baud_div_i on the first clock cycle and pulse clk_en_o on that cycle.

Configuration
- REQ-031 SHALL support macro UART_TX_SCHED_GAP_EN.
- REQ-032 SHALL, when UART_TX_SCHED_GAP_EN is defined: add input gap_i [7:0]; on entry to GAP load gap_i; decrement on each clk_en_o pulse; go to IDLE when the counter is 0 (gap_i=0 leaves GAP the next cycle).
- REQ-033 SHALL, when UART_TX_SCHED_GAP_EN is undefined: have no gap_i port, no GAP state and no gap counter; WAIT goes directly to IDLE.

Verification
- REQ-034 SHALL cover: baud_div_i=3 -> clk_en_o high 1 of every 4 cycles; baud_div_i=0 -> clk_en_o constantly high.
- REQ-035 SHALL cover: req0 only, data 0x155, transmitter model cleared tx_rdy_i after 3 cycles -> req0_ready_o 1-cycle pulse, tx_data_o=0x155, tx_start_o held 3 cycles, then busy_o low after tx_rdy_i rises.
- REQ-036 SHALL cover: both valid continuously for 4 frames -> grant order 0,1,0,1, each with exactly one ready pulse per frame.
- REQ-037 SHALL cover (GAP_EN defined): gap_i=2, baud_div_i=1 -> next tx_start_o no earlier than 2 clk_en_o pulses after tx_rdy_i rises; gap_i=0 -> back-to-back frames.
- REQ-038 SHALL cover: en_i dropped during WAIT -> frame completes, no further grants, valid requests pend with ready low; en_i=1 resumes.
- REQ-039 SHALL cover: rst_ni pulled low during START with tx_start_o=1 -> tx_start_o, busy_o and tx_data_o are 0 immediately; after release req0 wins a tie.
